rll_key_loader: RTL and testbench
=================================

Name: rll_key_loader

Overview:
- Sequential key-delivery front end for the RLL-locked combinational netlists (32 key inputs, XOR/XNOR key gates).
- Receives a key frame bit-serially from the secure key source, checks it against an 8-bit checksum, and commits it atomically to a register whose outputs drive the locked netlist's keyIn_0_0..keyIn_0_31.
- Repeated bad frames force a permanent lockout with an all-zero key until reset.

Parameters:
- KEY_W, 32, key width in bits; must be a multiple of 8 and at least 8.
- MAX_FAIL, 3, consecutive failed frames (framing or checksum) that trigger lockout; range 1..15.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s_valid  input  1  serial bit valid.
- s_ready  output  1  loader can accept a bit.
- s_data  input  1  serial key/checksum bit.
- s_last  input  1  marks the final bit of a frame.
- key_out  output  KEY_W  committed key; bit i drives keyIn_0_i.
- key_valid  output  1  key_out holds a checksum-verified key.
- load_err  output  1  one-cycle pulse on a rejected frame.
- lockout  output  1  loader permanently locked until reset.
- busy  output  1  high while a frame is in progress (SHIFT or CHECK).

Behaviour:
- Reset (async assert, sync deassert to clk): state IDLE, key_out=0, key_valid=0, load_err=0, lockout=0, busy=0, fail_cnt=0, bit_cnt=0. s_ready=1 from the first edge after deassert.
- Transfer: a bit is accepted when s_valid && s_ready on a rising edge. No other cycle changes the shift register or bit_cnt.
- Frame format: KEY_W key bits MSB first (bit KEY_W-1 first), then 8 checksum bits MSB first. Total F = KEY_W+8 bits.
- Checksum: XOR of all KEY_W/8 key bytes.
- States:
  - IDLE: s_ready=1. The first accepted bit loads into the shift register, sets bit_cnt=1 and moves to SHIFT. An accepted bit with s_last=1 in IDLE is a framing error.
  - SHIFT: s_ready=1, busy=1.
    - Accepted bit with s_last=1 and bit_cnt==F-1 -> CHECK.
    - s_last=1 with bit_cnt<F-1 (early) -> framing error.
    - bit_cnt==F-1 with s_last=0 (missing) -> framing error.
  - CHECK: one cycle. s_ready=0, busy=1. Compare the received checksum with the computed checksum.
    - Match: key_out<=received key, key_valid<=1, fail_cnt<=0, go to IDLE.
    - Mismatch: checksum failure.
  - LOCKED: s_ready=0, busy=0, lockout=1, key_out=0, key_valid=0. Only rst_n exits.
- Failure handling (framing or checksum):
  - load_err pulses high for exactly one cycle, in the cycle after the offending edge.
  - fail_cnt increments. If the new value equals MAX_FAIL, go to LOCKED; otherwise go to IDLE.
  - The partial or bad frame is discarded. key_out and key_valid keep their previously committed values.
- Latency: final bit accepted at edge T -> CHECK during cycle T..T+1 -> key_out/key_valid/load_err visible after edge T+1.
- Atomicity: key_out never shows a partially shifted key. During a reload, the old key and key_valid=1 stay in place until a successful commit.
- Bubbles: s_valid may drop at any point mid-frame with no timeout; the loader simply waits.
- s_data and s_last are ignored when s_valid=0.
- Reset mid-frame: all outputs return to reset values immediately, with no clock required.
- fail_cnt saturates at MAX_FAIL. It resets only on a successful commit or on rst_n.

Test Plan:
- Reset, then frame key 0x12345678 + checksum 0x08 with s_valid held high -> after edge T+1, key_out=0x12345678, key_valid=1, load_err=0. s_ready is 0 for exactly one cycle (CHECK).
- After the above, frame 0xDEADBEEF + wrong checksum 0x00 (correct is 0x22) -> one-cycle load_err. key_out stays 0x12345678, key_valid stays 1.
- Three consecutive bad-checksum frames (MAX_FAIL=3) -> third load_err, then lockout=1, key_out=0, key_valid=0, s_ready=0. Further s_valid is ignored until rst_n.
- s_last asserted on bit 10 -> load_err pulse, state IDLE. A subsequent valid frame 0xA5A50F0F + 0x00 commits and clears fail_cnt.
- Valid frame sent with s_valid toggling 1/0 every cycle plus random 0-5 cycle gaps -> identical commit of 0x12345678.
- rst_n pulsed low after 20 bits of a frame -> all outputs 0 asynchronously. A fresh complete frame afterwards commits correctly.

Source files
------------

// File: rtl/rll_key_loader.sv
// Bit-serial key loader: shifts in a KEY_W-bit key plus an 8-bit XOR checksum,
// commits verified keys atomically, and locks out after MAX_FAIL consecutive bad frames.
module rll_key_loader #(
  parameter int KEY_W    = 32,
  parameter int MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_data,
  input  logic             s_last,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             load_err,
  output logic             lockout,
  output logic             busy
);

  localparam int F  = KEY_W + 8;
  localparam int CW = $clog2(F + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(F - 1);
  localparam logic [3:0]    MAX_F    = 4'(MAX_FAIL);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [3:0]        fail_cnt_q, fail_cnt_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic              key_valid_q, key_valid_d;
  logic              load_err_q, load_err_d;
  logic              rdy_en_q;
  logic [F-1:0]      sr_q, sr_d;
  logic              accept;
  logic              fail;
  logic [3:0]        fail_inc;

  function automatic logic [7:0] calc_cks(input logic [KEY_W-1:0] k);
    logic [7:0] c;
    c = 8'h00;
    for (int b = 0; b < KEY_W / 8; b++) c = c ^ k[b*8 +: 8];
    return c;
  endfunction

  // s_ready is held low while in reset and rises on the first edge after release.
  assign s_ready   = rdy_en_q && ((state_q == IDLE) || (state_q == SHIFT));
  assign busy      = (state_q == SHIFT) || (state_q == CHECK);
  assign lockout   = (state_q == LOCKED);
  assign key_out   = key_q;
  assign key_valid = key_valid_q;
  assign load_err  = load_err_q;
  assign accept    = s_valid && s_ready;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    load_err_d  = 1'b0;
    sr_d        = sr_q;
    fail        = 1'b0;
    fail_inc    = (fail_cnt_q == MAX_F) ? fail_cnt_q : fail_cnt_q + 4'd1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sr_d = {sr_q[F-2:0], s_data};
          if (s_last) begin
            fail = 1'b1;
          end else begin
            bit_cnt_d = CW'(1);
            state_d   = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (accept) begin
          sr_d = {sr_q[F-2:0], s_data};
          if (bit_cnt_q == LAST_CNT) begin
            if (s_last) state_d = CHECK;
            else        fail    = 1'b1;
          end else if (s_last) begin
            fail = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      CHECK: begin
        bit_cnt_d = '0;
        if (calc_cks(sr_q[F-1:8]) == sr_q[7:0]) begin
          key_d       = sr_q[F-1:8];
          key_valid_d = 1'b1;
          fail_cnt_d  = '0;
          state_d     = IDLE;
        end else begin
          fail = 1'b1;
        end
      end
      LOCKED: begin
        state_d = LOCKED;
      end
      default: state_d = IDLE;
    endcase

    // Any rejected frame is discarded; the committed key survives unless we lock out.
    if (fail) begin
      load_err_d = 1'b1;
      bit_cnt_d  = '0;
      fail_cnt_d = fail_inc;
      if (fail_inc == MAX_F) begin
        state_d     = LOCKED;
        key_d       = '0;
        key_valid_d = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      fail_cnt_q  <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      load_err_q  <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      load_err_q  <= load_err_d;
      rdy_en_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

endmodule

// File: tb/tb_rll_key_loader.sv
// Scoreboard bench for rll_key_loader: directed frames push expected frame outcomes,
// a monitor pops and compares whenever a frame completes or is rejected.
module tb_rll_key_loader;

  localparam int KEY_W    = 32;
  localparam int MAX_FAIL = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_data = 1'b0;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic [KEY_W-1:0]  key_out;
  logic              key_valid;
  logic              load_err;
  logic              lockout;
  logic              busy;

  typedef struct packed {
    logic        err;
    logic [31:0] key;
    logic        kv;
    logic        lock;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  rll_key_loader #(.KEY_W(KEY_W), .MAX_FAIL(MAX_FAIL)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .key_out(key_out), .key_valid(key_valid),
    .load_err(load_err), .lockout(lockout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor: a frame outcome is a load_err pulse or busy falling.
  initial begin
    bit   prev;
    exp_t e;
    exp_t a;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (load_err || (prev && !busy)) begin
          a = {load_err, key_out, key_valid, lockout};
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event actual=%h required=none", a);
          end else begin
            e = q.pop_front();
            if (a !== e) begin
              bad++;
              $display("FAIL frame_outcome actual err=%b key=%h kv=%b lock=%b required err=%b key=%h kv=%b lock=%b",
                       a.err, a.key, a.kv, a.lock, e.err, e.key, e.kv, e.lock);
            end
          end
        end
        prev = busy;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic err, input logic [31:0] key, input logic kv, input logic lock);
    exp_t e;
    e = {err, key, kv, lock};
    q.push_back(e);
  endtask

  // Called and returns at a falling edge.
  task automatic send_bit(input logic d, input logic last);
    int n;
    n = 0;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL s_ready_timeout actual=0 required=1");
    end else begin
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [39:0] fr, input int n, input bit mark_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send_bit(fr[39-i], mark_last && (i == n - 1));
      if (gaps && i != n - 1) begin
        s_data = 1'($urandom);
        s_last = 1'($urandom);
        repeat (1 + ((i % 4 == 0) ? $urandom_range(0, 5) : 0)) @(negedge clk);
        s_last = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout actual=%0d required=0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_key_out", 64'(key_out), 64'h0);
    chk("rst_flags", {59'h0, key_valid, load_err, lockout, busy, s_ready}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(s_ready), 64'h1);
  endtask

  initial begin
    int lo;
    do_reset();

    // Plain frame, s_valid held high; CHECK drops s_ready for exactly one cycle
    expect_ev(1'b0, 32'h12345678, 1'b1, 1'b0);
    send_bits({32'h12345678, 8'h08}, 40, 1'b1, 1'b0);
    lo = 0;
    for (int i = 0; i < 4; i++) begin
      if (!s_ready) lo++;
      @(negedge clk);
    end
    chk("ready_low_cycles", 64'(lo), 64'd1);
    drain();
    chk("commit_key", 64'(key_out), 64'h12345678);

    // Bad checksum keeps old key (fail_cnt=1)
    expect_ev(1'b1, 32'h12345678, 1'b1, 1'b0);
    send_bits({32'hDEADBEEF, 8'h00}, 40, 1'b1, 1'b0);
    drain();
    chk("bad_cks_key_kept", {31'h0, key_valid, key_out}, {31'h0, 1'b1, 32'h12345678});

    // Early s_last on bit 10 (fail_cnt=2), then a good frame clears fail_cnt
    expect_ev(1'b1, 32'h12345678, 1'b1, 1'b0);
    send_bits({32'hFFFF0000, 8'h00}, 10, 1'b1, 1'b0);
    drain();
    chk("early_last_idle", {62'h0, busy, s_ready}, 64'h1);
    expect_ev(1'b0, 32'hA5A50F0F, 1'b1, 1'b0);
    send_bits({32'hA5A50F0F, 8'h00}, 40, 1'b1, 1'b0);
    drain();

    // Missing s_last on the final bit, then bubbled frame commits
    expect_ev(1'b1, 32'hA5A50F0F, 1'b1, 1'b0);
    send_bits({32'h12345678, 8'h08}, 40, 1'b0, 1'b0);
    drain();
    expect_ev(1'b0, 32'h12345678, 1'b1, 1'b0);
    send_bits({32'h12345678, 8'h08}, 40, 1'b1, 1'b1);
    drain();
    chk("gapped_commit", 64'(key_out), 64'h12345678);

    // Three bad frames -> lockout (fail_cnt was cleared by the last commit)
    expect_ev(1'b1, 32'h12345678, 1'b1, 1'b0);
    send_bits({32'hDEADBEEF, 8'h00}, 40, 1'b1, 1'b0);
    expect_ev(1'b1, 32'h12345678, 1'b1, 1'b0);
    send_bits({32'hDEADBEEF, 8'h21}, 40, 1'b1, 1'b0);
    expect_ev(1'b1, 32'h00000000, 1'b0, 1'b1);
    send_bits({32'h12345678, 8'h09}, 40, 1'b1, 1'b0);
    drain();
    chk("locked_state", {31'h0, lockout, key_valid, s_ready, busy, key_out}, {31'h0, 4'b1000, 32'h0});
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'b1;
      s_data  = 1'b1;
      s_last  = (i == 11);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("locked_ignores", {31'h0, lockout, key_valid, busy, load_err, key_out}, {31'h0, 4'b1000, 32'h0});

    // Reset out of lockout, commit, then reset mid-frame
    do_reset();
    chk("unlocked", 64'(lockout), 64'h0);
    expect_ev(1'b0, 32'hA5A50F0F, 1'b1, 1'b0);
    send_bits({32'hA5A50F0F, 8'h00}, 40, 1'b1, 1'b0);
    drain();
    send_bits({32'hDEADBEEF, 8'h22}, 20, 1'b0, 1'b0);
    chk("midframe_busy", {31'h0, busy, key_out}, {31'h0, 1'b1, 32'hA5A50F0F});
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {28'h0, key_valid, load_err, lockout, busy, key_out}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_ev(1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
    send_bits({32'hDEADBEEF, 8'h22}, 40, 1'b1, 1'b0);
    drain();
    chk("post_rst_commit", {31'h0, key_valid, key_out}, {31'h0, 1'b1, 32'hDEADBEEF});

    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
